// File: rtl/sd_dat_rx_if.sv
// Avalon-MM slave bus bundle for the SD data receiver.
// The CPU side drives the master modport; the receiver uses the slave modport.
interface sd_dat_rx_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, read, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, read, write_n, writedata, output readdata);
endinterface

// File: rtl/sd_dat_rx.sv
// 4-bit SD read-block receiver: start-bit detect, nibble-to-word packing, word FIFO and Avalon-MM registers.
// Define SD_DAT_RX_CRC_CHECK_EN to build the four per-line CRC16 checkers; otherwise only the end bit is checked.
module sd_dat_rx #(
    parameter int BLOCK_BYTES = 512,
    parameter int FIFO_DEPTH  = 8,
    parameter int TMO_W       = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    sd_dat_rx_if.slave bus,
    input  logic       sd_sample,
    input  logic [3:0] sd_dat_in,
    output logic       irq
);
    localparam int NIBBLES = BLOCK_BYTES * 2;
    localparam int NW      = $clog2(NIBBLES);
    localparam int BW      = $clog2(BLOCK_BYTES + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam logic [NW-1:0] NIB_LAST  = NW'(NIBBLES - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END} state_t;
    state_t r_state, w_stateNext;

    logic [NW-1:0]    r_nibCnt;
    logic [3:0]       r_crcCnt;
    logic [TMO_W-1:0] r_tmoCnt, r_tmoReg, w_tmoNext;
    logic [BW-1:0]    r_byteCnt;
    logic [3:0]       r_hiNib;
    logic [31:0]      r_word, r_readdata, w_pushWord, w_rdMux;
    logic             r_done, r_crcErr, r_tmoFlag, r_overrun, r_irqEn, r_irq;
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wrPtr, r_rdPtr;
    logic [AW:0]      r_count;

    logic w_ctrlWr, w_tmoWr, w_abort, w_start, w_flush, w_pop, w_full, w_smp;
    logic w_push, w_doPush, w_setTmo, w_setDone, w_endBad, w_crcBad;
    logic w_doneNext, w_irqEnNext, w_unusedBits;
    logic [7:0] w_byte;

    assign w_ctrlWr    = bus.chipselect & ~bus.write_n & (bus.address == 2'd0);
    assign w_tmoWr     = bus.chipselect & ~bus.write_n & (bus.address == 2'd2);
    assign w_abort     = w_ctrlWr & bus.writedata[1];
    assign w_start     = w_ctrlWr & bus.writedata[0] & ~bus.writedata[1] & (r_state == S_IDLE);
    assign w_flush     = w_abort | w_start;
    assign w_pop       = bus.chipselect & bus.read & (bus.address == 2'd1) & (r_count != '0);
    assign w_full      = (r_count == FIFO_FULL);
    assign w_doPush    = w_push & ~w_full;
    assign w_smp       = sd_sample & ~w_abort;
    assign w_byte      = {r_hiNib, sd_dat_in};
    assign w_pushWord  = {w_byte, r_word[31:8]};
    assign w_tmoNext   = r_tmoCnt + TMO_W'(1);
    assign w_doneNext  = w_start ? 1'b0 : (w_setDone | r_done);
    assign w_irqEnNext = w_ctrlWr ? bus.writedata[2] : r_irqEn;
    assign w_unusedBits = ^bus.writedata[31:TMO_W];
    assign bus.readdata = r_readdata;
    assign irq          = r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_stateNext;
    end

    // Abort overrides everything; otherwise the FSM only advances on SD clock strobes.
    always_comb begin
        w_stateNext = r_state;
        w_push      = 1'b0;
        w_setTmo    = 1'b0;
        w_setDone   = 1'b0;
        w_endBad    = 1'b0;
        if (w_abort) begin
            w_stateNext = S_IDLE;
        end else if (w_start) begin
            w_stateNext = S_WAIT_START;
        end else if (sd_sample) begin
            case (r_state)
                S_WAIT_START: begin
                    if (sd_dat_in == 4'h0) begin
                        w_stateNext = S_DATA;
                    end else if ((r_tmoReg != '0) && (w_tmoNext == r_tmoReg)) begin
                        w_setTmo    = 1'b1;
                        w_setDone   = 1'b1;
                        w_stateNext = S_IDLE;
                    end
                end
                S_DATA: begin
                    w_push = r_nibCnt[0] & (r_nibCnt[2:1] == 2'd3);
                    if (r_nibCnt == NIB_LAST) w_stateNext = S_CRC;
                end
                S_CRC: begin
                    if (r_crcCnt == 4'd15) w_stateNext = S_END;
                end
                S_END: begin
                    w_setDone   = 1'b1;
                    w_endBad    = (sd_dat_in != 4'hF) | w_crcBad;
                    w_stateNext = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rdMux = '0;
        case (bus.address)
            2'd0: w_rdMux = {26'b0, r_irqEn, r_overrun, r_tmoFlag, r_crcErr, r_done, (r_state != S_IDLE)};
            2'd1: w_rdMux = (r_count != '0) ? r_mem[r_rdPtr] : 32'h0;
            2'd2: w_rdMux = 32'(r_tmoReg);
            2'd3: w_rdMux = 32'(r_byteCnt);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= w_pushWord;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_nibCnt   <= '0;
            r_crcCnt   <= '0;
            r_tmoCnt   <= '0;
            r_tmoReg   <= '0;
            r_byteCnt  <= '0;
            r_hiNib    <= '0;
            r_word     <= '0;
            r_readdata <= '0;
            r_done     <= 1'b0;
            r_crcErr   <= 1'b0;
            r_tmoFlag  <= 1'b0;
            r_overrun  <= 1'b0;
            r_irqEn    <= 1'b0;
            r_irq      <= 1'b0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
        end else begin
            r_readdata <= w_rdMux;
            r_done     <= w_doneNext;
            r_irqEn    <= w_irqEnNext;
            r_irq      <= w_doneNext & w_irqEnNext;
            if (w_tmoWr)             r_tmoReg  <= bus.writedata[TMO_W-1:0];
            if (w_setTmo)            r_tmoFlag <= 1'b1;
            if (w_endBad)            r_crcErr  <= 1'b1;
            if (w_push && w_full)    r_overrun <= 1'b1;
            if (w_start) begin
                r_crcErr  <= 1'b0;
                r_tmoFlag <= 1'b0;
                r_overrun <= 1'b0;
                r_byteCnt <= '0;
                r_tmoCnt  <= '0;
            end
            if (w_smp) begin
                case (r_state)
                    S_WAIT_START: begin
                        if (sd_dat_in == 4'h0) begin
                            r_nibCnt <= '0;
                            r_crcCnt <= '0;
                        end else begin
                            r_tmoCnt <= w_tmoNext;
                        end
                    end
                    S_DATA: begin
                        r_nibCnt <= r_nibCnt + NW'(1);
                        if (!r_nibCnt[0]) begin
                            r_hiNib <= sd_dat_in;
                        end else begin
                            r_word    <= w_pushWord;
                            r_byteCnt <= r_byteCnt + BW'(1);
                        end
                    end
                    S_CRC:   r_crcCnt <= r_crcCnt + 4'd1;
                    default: ;
                endcase
            end
            // A full FIFO drops the new word, so the count only moves on an accepted push.
            if (w_flush) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
                r_count <= '0;
            end else begin
                if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
                if (w_pop)    r_rdPtr <= r_rdPtr + AW'(1);
                case ({w_doPush, w_pop})
                    2'b10:   r_count <= r_count + (AW + 1)'(1);
                    2'b01:   r_count <= r_count - (AW + 1)'(1);
                    default: ;
                endcase
            end
        end
    end

`ifdef SD_DAT_RX_CRC_CHECK_EN
    logic [15:0] r_crc [4];
    logic        r_crcBad;

    // Each line runs its own CRC16 over data bits; the received CRC is then compared MSB first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) r_crc[i] <= '0;
            r_crcBad <= 1'b0;
        end else if (w_smp) begin
            case (r_state)
                S_WAIT_START: begin
                    if (sd_dat_in == 4'h0) begin
                        for (int i = 0; i < 4; i++) r_crc[i] <= '0;
                        r_crcBad <= 1'b0;
                    end
                end
                S_DATA: begin
                    for (int i = 0; i < 4; i++)
                        r_crc[i] <= {r_crc[i][14:0], 1'b0} ^ ((r_crc[i][15] ^ sd_dat_in[i]) ? 16'h1021 : 16'h0000);
                end
                S_CRC: begin
                    for (int i = 0; i < 4; i++) begin
                        if (sd_dat_in[i] != r_crc[i][15]) r_crcBad <= 1'b1;
                        r_crc[i] <= {r_crc[i][14:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_crcBad = r_crcBad;
`else
    assign w_crcBad = 1'b0;
`endif
endmodule

// File: tb/tb_sd_dat_rx.sv
// Directed bench for sd_dat_rx: one 8-byte-block instance and one 16-byte-block, 2-deep-FIFO instance.
// Expected FIFO words come from a scoreboard queue filled as block bytes are driven.
module tb_sd_dat_rx;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       sd_sample;
    logic [3:0] sd_dat_in;
    logic       irq1, irq2;

    sd_dat_rx_if bus1 ();
    sd_dat_rx_if bus2 ();

    sd_dat_rx #(.BLOCK_BYTES(8), .FIFO_DEPTH(8), .TMO_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus1), .sd_sample(sd_sample), .sd_dat_in(sd_dat_in), .irq(irq1));

    sd_dat_rx #(.BLOCK_BYTES(16), .FIFO_DEPTH(2), .TMO_W(16)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2), .sd_sample(sd_sample), .sd_dat_in(sd_dat_in), .irq(irq2));

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] expQ [$];
    logic        modelOverrun;
    logic [31:0] rd;
    logic [31:0] crcExp;

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One SD clock strobe carrying one nibble on DAT[3:0].
    task automatic applyStimulus(input logic [3:0] nib);
        @(negedge clk);
        sd_dat_in = nib;
        sd_sample = 1'b1;
        @(negedge clk);
        sd_sample = 1'b0;
    endtask

    task automatic busWrite(input int sel, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        if (sel == 1) begin
            bus1.chipselect = 1'b1; bus1.write_n = 1'b0; bus1.address = a; bus1.writedata = d;
        end else begin
            bus2.chipselect = 1'b1; bus2.write_n = 1'b0; bus2.address = a; bus2.writedata = d;
        end
        @(negedge clk);
        bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.address = 2'd0;
        bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.address = 2'd0;
    endtask

    task automatic busRead(input int sel, input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        if (sel == 1) begin
            bus1.chipselect = 1'b1; bus1.read = 1'b1; bus1.address = a;
        end else begin
            bus2.chipselect = 1'b1; bus2.read = 1'b1; bus2.address = a;
        end
        @(negedge clk);
        d = (sel == 1) ? bus1.readdata : bus2.readdata;
        bus1.chipselect = 1'b0; bus1.read = 1'b0; bus1.address = 2'd0;
        bus2.chipselect = 1'b0; bus2.read = 1'b0; bus2.address = 2'd0;
    endtask

    task automatic readWord(input int sel, input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        busRead(sel, 2'd1, d);
        exp = (expQ.size() != 0) ? expQ.pop_front() : 32'h0;
        checkOutput(tag, d, exp);
    endtask

    // CRC16 (x^16+x^12+x^5+1, init 0) over the bits one DAT line carries for bytes 1..nbytes.
    function automatic logic [15:0] crcLine(input int nbytes, input int line);
        logic [15:0] crc;
        logic [7:0]  b;
        logic        dbit;
        crc = '0;
        for (int j = 0; j < nbytes; j++) begin
            b = 8'(j + 1);
            for (int h = 1; h >= 0; h--) begin
                dbit = b[h*4 + line];
                if (crc[15] ^ dbit) crc = {crc[14:0], 1'b0} ^ 16'h1021;
                else                crc = {crc[14:0], 1'b0};
            end
        end
        return crc;
    endfunction

    // Drives start nibble, bytes 01..nbytes, crcSamples CRC nibbles and (if all 16) the end nibble.
    task automatic sendBlock(input int nbytes, input int depth, input int flipLine, input int flipBit,
                             input int crcSamples, input logic [3:0] endNib);
        logic [15:0] crc [4];
        logic [7:0]  b;
        logic [31:0] w;
        logic [3:0]  nib;
        for (int i = 0; i < 4; i++) crc[i] = crcLine(nbytes, i);
        if (flipLine >= 0) crc[flipLine][flipBit] = ~crc[flipLine][flipBit];
        applyStimulus(4'h0);
        w = '0;
        for (int j = 0; j < nbytes; j++) begin
            b = 8'(j + 1);
            applyStimulus(b[7:4]);
            applyStimulus(b[3:0]);
            w[8*(j%4) +: 8] = b;
            if ((j % 4) == 3) begin
                if (expQ.size() < depth) expQ.push_back(w);
                else                     modelOverrun = 1'b1;
            end
        end
        for (int k = 15; k >= 16 - crcSamples; k--) begin
            for (int i = 0; i < 4; i++) nib[i] = crc[i][k];
            applyStimulus(nib);
        end
        if (crcSamples == 16) applyStimulus(endNib);
    endtask

    initial begin
        reset_n   = 1'b0;
        sd_sample = 1'b0;
        sd_dat_in = 4'hF;
        bus1.chipselect = 1'b0; bus1.read = 1'b0; bus1.write_n = 1'b1; bus1.address = 2'd0; bus1.writedata = '0;
        bus2.chipselect = 1'b0; bus2.read = 1'b0; bus2.write_n = 1'b1; bus2.address = 2'd0; bus2.writedata = '0;
        modelOverrun = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_readdata", bus1.readdata, 32'h0);
        checkOutput("rst_irq", {31'b0, irq1}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        busRead(1, 2'd0, rd); checkOutput("rst_status", rd, 32'h0);
        busRead(1, 2'd2, rd); checkOutput("rst_timeout", rd, 32'h0);
        busRead(1, 2'd3, rd); checkOutput("rst_bytecnt", rd, 32'h0);
        readWord(1, "rst_fifo_empty");

        $display("[TB] good block");
        busWrite(1, 2'd2, 32'd100);
        busRead(1, 2'd2, rd); checkOutput("t1_timeout_rb", rd, 32'd100);
        busWrite(1, 2'd0, 32'h5);
        busRead(1, 2'd0, rd); checkOutput("t1_busy", rd, 32'h21);
        sendBlock(8, 8, -1, 0, 16, 4'hF);
        busRead(1, 2'd0, rd); checkOutput("t1_status", rd, 32'h22);
        checkOutput("t1_irq", {31'b0, irq1}, 32'h1);
        busRead(1, 2'd3, rd); checkOutput("t1_bytecnt", rd, 32'd8);
        readWord(1, "t1_word0");
        readWord(1, "t1_word1");
        readWord(1, "t1_empty");

        $display("[TB] line 2 CRC bit 5 flipped");
        busWrite(1, 2'd0, 32'h5);
        checkOutput("t2_irq_clr", {31'b0, irq1}, 32'h0);
        sendBlock(8, 8, 2, 5, 16, 4'hF);
`ifdef SD_DAT_RX_CRC_CHECK_EN
        crcExp = 32'h26;
`else
        crcExp = 32'h22;
`endif
        busRead(1, 2'd0, rd); checkOutput("t2_status", rd, crcExp);
        readWord(1, "t2_word0");
        readWord(1, "t2_word1");

        $display("[TB] bad end bit");
        busWrite(1, 2'd0, 32'h5);
        busRead(1, 2'd0, rd); checkOutput("t2b_flags_clr", rd, 32'h21);
        sendBlock(8, 8, -1, 0, 16, 4'hE);
        busRead(1, 2'd0, rd); checkOutput("t2b_status", rd, 32'h26);
        readWord(1, "t2b_word0");
        readWord(1, "t2b_word1");

        $display("[TB] timeout");
        busWrite(1, 2'd2, 32'd10);
        busWrite(1, 2'd0, 32'h5);
        repeat (9) applyStimulus(4'hF);
        busRead(1, 2'd0, rd); checkOutput("t3_before_tmo", rd, 32'h21);
        applyStimulus(4'hF);
        busRead(1, 2'd0, rd); checkOutput("t3_status", rd, 32'h2A);
        checkOutput("t3_irq", {31'b0, irq1}, 32'h1);
        readWord(1, "t3_fifo_empty");

        $display("[TB] overrun on 2-deep FIFO");
        modelOverrun = 1'b0;
        busWrite(2, 2'd0, 32'h1);
        sendBlock(16, 2, -1, 0, 16, 4'hF);
        busRead(2, 2'd0, rd); checkOutput("t4_status", rd, 32'h02 | (modelOverrun ? 32'h10 : 32'h0));
        checkOutput("t4_irq", {31'b0, irq2}, 32'h0);
        busRead(2, 2'd3, rd); checkOutput("t4_bytecnt", rd, 32'd16);
        readWord(2, "t4_word0");
        readWord(2, "t4_word1");
        readWord(2, "t4_empty");

        $display("[TB] abort in DATA");
        busWrite(1, 2'd0, 32'h1);
        applyStimulus(4'h0);
        for (int j = 0; j < 5; j++) begin
            applyStimulus(4'h3);
            applyStimulus(4'(j));
        end
        busWrite(1, 2'd0, 32'h6);
        busRead(1, 2'd0, rd); checkOutput("t5_status", rd, 32'h20);
        readWord(1, "t5_fifo_flushed");
        busRead(1, 2'd3, rd); checkOutput("t5_bytecnt", rd, 32'd5);
        busWrite(1, 2'd0, 32'h3);
        busRead(1, 2'd0, rd); checkOutput("t5_abort_wins", rd, 32'h00);
        busWrite(1, 2'd0, 32'h1);
        busRead(1, 2'd0, rd); checkOutput("t5_restart", rd, 32'h01);

        $display("[TB] reset mid-CRC");
        sendBlock(8, 8, -1, 0, 5, 4'hF);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t6_readdata1", bus1.readdata, 32'h0);
        checkOutput("t6_readdata2", bus2.readdata, 32'h0);
        checkOutput("t6_irq", {31'b0, irq1}, 32'h0);
        expQ.delete();
        @(negedge clk);
        reset_n = 1'b1;
        busRead(1, 2'd0, rd); checkOutput("t6_status", rd, 32'h0);
        readWord(1, "t6_fifo_empty");
        busRead(1, 2'd2, rd); checkOutput("t6_timeout", rd, 32'h0);
        busRead(1, 2'd3, rd); checkOutput("t6_bytecnt", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
